// File: rtl/pcap_axis_player.sv
// rtl/pcap_axis_player.sv - capture AXI-Stream packets into a linear buffer and replay them
// Replay reads the RAM at the next-state address so back-to-back packets need no bubble.
module pcap_axis_player #(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int KEEP_WIDTH      = AXIS_DATA_WIDTH/8,
   parameter int BUF_WORDS       = 1024,
   parameter int MAX_PKTS        = 16,
   parameter int GAP_WIDTH       = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       s_axis_tvalid_i,
   output logic                       s_axis_tready_o,
   input  logic                       s_axis_tlast_i,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
   input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep_i,
   input  logic                       s_axis_tuser_i,
   output logic                       m_axis_tvalid_o,
   input  logic                       m_axis_tready_i,
   output logic                       m_axis_tlast_o,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
   output logic [KEEP_WIDTH-1:0]      m_axis_tkeep_o,
   output logic                       m_axis_tuser_o,
   input  logic [GAP_WIDTH-1:0]       cfg_gap_i,
   input  logic                       cfg_loop_i,
   input  logic                       start_i,
   input  logic                       stop_i,
   input  logic                       clear_i,
   output logic                       busy_o,
   output logic [$clog2(MAX_PKTS):0]  pkt_count_o,
   output logic                       drop_o
);
   localparam int AW = $clog2(BUF_WORDS);
   localparam int DW = $clog2(MAX_PKTS);
   localparam int CW = AW + 1;
   localparam int PW = DW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;
   state_t state_q, state_d;

   logic [AXIS_DATA_WIDTH-1:0] mem [BUF_WORDS];
   logic [AXIS_DATA_WIDTH-1:0] mem_q;
   logic [AXIS_DATA_WIDTH-1:0] data_mask;
   logic [AW-1:0]              d_addr [MAX_PKTS];
   logic [CW-1:0]              d_cnt  [MAX_PKTS];
   logic [KEEP_WIDTH-1:0]      d_keep [MAX_PKTS];

   logic [CW-1:0]        wr_ptr_q, pkt_start_q, beat_left_q;
   logic [PW-1:0]        pkt_cnt_q;
   logic                 in_pkt_q, discard_q, stop_pend_q;
   logic [AW-1:0]        rd_addr_q, rd_next;
   logic [DW-1:0]        d_idx_q, d_next;
   logic [GAP_WIDTH-1:0] gap_cnt_q;

   logic play, hs, last_desc, start_ok, stop_any;
   logic ld_beat, ld_bad, ld_end, ld_drop, clr;

   assign play            = (state_q == ST_PLAY);
   assign busy_o          = (state_q != ST_IDLE);
   assign s_axis_tready_o = (state_q == ST_IDLE);
   assign pkt_count_o     = pkt_cnt_q;
   assign m_axis_tuser_o  = 1'b0;

   // Loading only happens in IDLE; a bad packet keeps being accepted until its tlast.
   assign ld_beat = s_axis_tvalid_i & s_axis_tready_o;
   assign ld_bad  = wr_ptr_q[AW] | (in_pkt_q ? discard_q : (pkt_cnt_q == PW'(MAX_PKTS)));
   assign ld_end  = ld_beat & s_axis_tlast_i;
   assign ld_drop = ld_end & (ld_bad | s_axis_tuser_i);
   assign clr     = clear_i & s_axis_tready_o;

   assign m_axis_tvalid_o = play;
   assign m_axis_tlast_o  = play & (beat_left_q == CW'(1));
   assign m_axis_tkeep_o  = !play ? '0 : (m_axis_tlast_o ? d_keep[d_idx_q] : '1);
   assign hs              = play & m_axis_tready_i;
   assign last_desc       = ({1'b0, d_idx_q} == pkt_cnt_q - PW'(1));
   assign d_next          = last_desc ? '0 : d_idx_q + DW'(1);
   assign start_ok        = start_i & ~clear_i & (state_q == ST_IDLE) & (pkt_cnt_q != '0);
   assign stop_any        = stop_pend_q | stop_i;

   always_comb begin
      data_mask = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) data_mask[i*8 +: 8] = {8{m_axis_tkeep_o[i]}};
   end
   assign m_axis_tdata_o = mem_q & data_mask;

   always_comb begin
      state_d = state_q;
      rd_next = rd_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_PLAY;
               rd_next = d_addr[0];
            end
         end
         ST_PLAY: begin
            if (hs) begin
               if (m_axis_tlast_o) begin
                  rd_next = d_addr[d_next];
                  if (stop_any || (last_desc && !cfg_loop_i)) state_d = ST_IDLE;
                  else if (cfg_gap_i != '0)                    state_d = ST_GAP;
               end else begin
                  rd_next = rd_addr_q + AW'(1);
               end
            end
         end
         ST_GAP: begin
            if (stop_any)                           state_d = ST_IDLE;
            else if (gap_cnt_q == GAP_WIDTH'(1))    state_d = ST_PLAY;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_addr_q   <= '0;
         d_idx_q     <= '0;
         beat_left_q <= '0;
         gap_cnt_q   <= '0;
         stop_pend_q <= 1'b0;
         wr_ptr_q    <= '0;
         pkt_start_q <= '0;
         pkt_cnt_q   <= '0;
         in_pkt_q    <= 1'b0;
         discard_q   <= 1'b0;
         drop_o      <= 1'b0;
      end else begin
         rd_addr_q <= rd_next;
         if (state_q == ST_IDLE) stop_pend_q <= 1'b0;
         else if (stop_i)        stop_pend_q <= 1'b1;

         if (start_ok) begin
            d_idx_q     <= '0;
            beat_left_q <= d_cnt[0];
         end else if (hs) begin
            if (m_axis_tlast_o) begin
               d_idx_q     <= d_next;
               beat_left_q <= d_cnt[d_next];
               gap_cnt_q   <= cfg_gap_i;
            end else begin
               beat_left_q <= beat_left_q - CW'(1);
            end
         end else if (state_q == ST_GAP) begin
            gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
         end

         drop_o <= 1'b0;
         if (clr) begin
            pkt_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            pkt_start_q <= '0;
            in_pkt_q    <= 1'b0;
            discard_q   <= 1'b0;
         end else if (ld_beat) begin
            if (!s_axis_tlast_i) begin
               in_pkt_q  <= 1'b1;
               discard_q <= ld_bad;
               if (!ld_bad) wr_ptr_q <= wr_ptr_q + CW'(1);
            end else begin
               in_pkt_q  <= 1'b0;
               discard_q <= 1'b0;
               if (ld_drop) begin
                  wr_ptr_q <= pkt_start_q;
                  drop_o   <= 1'b1;
               end else begin
                  wr_ptr_q    <= wr_ptr_q + CW'(1);
                  pkt_start_q <= wr_ptr_q + CW'(1);
                  pkt_cnt_q   <= pkt_cnt_q + PW'(1);
               end
            end
         end
      end
   end

   // Packet RAM and descriptor table carry no reset; validity is tracked by pkt_cnt_q.
   always_ff @(posedge clk_i) begin
      if (ld_beat && !ld_bad) mem[wr_ptr_q[AW-1:0]] <= s_axis_tdata_i;
      mem_q <= mem[rd_next];
      if (ld_end && !ld_drop && !clr) begin
         d_addr[pkt_cnt_q[DW-1:0]] <= pkt_start_q[AW-1:0];
         d_cnt[pkt_cnt_q[DW-1:0]]  <= wr_ptr_q + CW'(1) - pkt_start_q;
         d_keep[pkt_cnt_q[DW-1:0]] <= s_axis_tkeep_i;
      end
   end
endmodule

// File: tb/tb_pcap_axis_player.sv
// tb/tb_pcap_axis_player.sv - directed bench for pcap_axis_player
module tb_pcap_axis_player;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_tvalid, s_tlast, s_tuser;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        m_tready = 1'b1;
   logic [7:0]  cfg_gap;
   logic        cfg_loop, start, stop, clear;

   logic        a_sready, a_tvalid, a_tlast, a_tuser, a_busy, a_drop;
   logic [63:0] a_tdata;
   logic [7:0]  a_tkeep;
   logic [4:0]  a_pkt;
   logic        b_sready, b_tvalid, b_tlast, b_tuser, b_busy, b_drop;
   logic [63:0] b_tdata;
   logic [7:0]  b_tkeep;
   logic [4:0]  b_pkt;

   always #5 clk = ~clk;

   pcap_axis_player u_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(a_sready), .s_axis_tlast_i(s_tlast),
      .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tuser_i(s_tuser),
      .m_axis_tvalid_o(a_tvalid), .m_axis_tready_i(m_tready), .m_axis_tlast_o(a_tlast),
      .m_axis_tdata_o(a_tdata), .m_axis_tkeep_o(a_tkeep), .m_axis_tuser_o(a_tuser),
      .cfg_gap_i(cfg_gap), .cfg_loop_i(cfg_loop), .start_i(start), .stop_i(stop),
      .clear_i(clear), .busy_o(a_busy), .pkt_count_o(a_pkt), .drop_o(a_drop));

   pcap_axis_player #(.BUF_WORDS(16)) u_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(b_sready), .s_axis_tlast_i(s_tlast),
      .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tuser_i(s_tuser),
      .m_axis_tvalid_o(b_tvalid), .m_axis_tready_i(m_tready), .m_axis_tlast_o(b_tlast),
      .m_axis_tdata_o(b_tdata), .m_axis_tkeep_o(b_tkeep), .m_axis_tuser_o(b_tuser),
      .cfg_gap_i(cfg_gap), .cfg_loop_i(cfg_loop), .start_i(start), .stop_i(stop),
      .clear_i(clear), .busy_o(b_busy), .pkt_count_o(b_pkt), .drop_o(b_drop));

   logic        sel, mon_clr, rdy_mode;
   logic        m_valid, m_last;
   logic [63:0] m_data;
   logic [7:0]  m_keep;
   assign m_valid = sel ? b_tvalid : a_tvalid;
   assign m_last  = sel ? b_tlast  : a_tlast;
   assign m_data  = sel ? b_tdata  : a_tdata;
   assign m_keep  = sel ? b_tkeep  : a_tkeep;

   logic [63:0] got_d[$], exp_d[$];
   logic [7:0]  got_k[$], exp_k[$];
   bit          got_l[$], exp_l[$];
   int          gap_q[$];
   int          idle_n, hold_cnt, hold_errs, drop_a, drop_b, pat_i;
   bit          after_last, pv, pr, pl;
   logic [63:0] pd;
   logic [7:0]  pk;
   bit          pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   // Ready is chosen first so the sampled handshake is the one the next posedge sees.
   always @(negedge clk) begin
      if (rdy_mode) begin
         m_tready = pat[pat_i];
         pat_i = (pat_i == 4) ? 0 : pat_i + 1;
      end else begin
         m_tready = 1'b1;
      end
      if (mon_clr) begin
         got_d.delete(); got_k.delete(); got_l.delete(); gap_q.delete();
         after_last = 0; idle_n = 0; hold_cnt = 0; hold_errs = 0; drop_a = 0; drop_b = 0;
      end else if (rst_n) begin
         if (pv && !pr) begin
            hold_cnt++;
            if (!m_valid || m_data !== pd || m_keep !== pk || m_last !== pl) hold_errs++;
         end
         if (after_last) begin
            if (m_valid) begin
               gap_q.push_back(idle_n);
               after_last = 0;
            end else begin
               idle_n++;
            end
         end
         if (m_valid && m_tready) begin
            got_d.push_back(m_data); got_k.push_back(m_keep); got_l.push_back(m_last);
            if (m_last) begin
               after_last = 1;
               idle_n = 0;
            end
         end
         if (a_drop) drop_a++;
         if (b_drop) drop_b++;
      end
      pv = m_valid; pr = m_tready; pd = m_data; pk = m_keep; pl = m_last;
   end

   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] word_of(input int p, input int w, input int n, input bit masked);
      logic [63:0] v;
      int b;
      for (int i = 0; i < 8; i++) begin
         b = w*8 + i;
         if (b < n)        v[i*8 +: 8] = 8'((p*37 + b*3 + 1) & 255);
         else if (masked)  v[i*8 +: 8] = 8'h00;
         else              v[i*8 +: 8] = 8'(8'hC0 + i);
      end
      return v;
   endfunction

   function automatic logic [7:0] keep_of(input int w, input int n);
      int rem;
      rem = n - w*8;
      if (rem >= 8) return 8'hFF;
      return 8'((16'h1 << rem) - 1);
   endfunction

   task automatic send_pkt(input int p, input int n, input bit user, input bit clr_last);
      int nb;
      nb = (n + 7) / 8;
      for (int w = 0; w < nb; w++) begin
         s_tvalid = 1'b1;
         s_tdata  = word_of(p, w, n, 1'b0);
         s_tkeep  = keep_of(w, n);
         s_tlast  = (w == nb - 1);
         s_tuser  = user && (w == nb - 1);
         clear    = clr_last && (w == nb - 1);
         step();
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; clear = 1'b0;
   endtask

   task automatic exp_pkt(input int p, input int n);
      int nb;
      nb = (n + 7) / 8;
      for (int w = 0; w < nb; w++) begin
         exp_d.push_back(word_of(p, w, n, 1'b1));
         exp_k.push_back(keep_of(w, n));
         exp_l.push_back(w == nb - 1);
      end
   endtask

   task automatic new_run();
      exp_d.delete(); exp_k.delete(); exp_l.delete();
      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
   endtask

   task automatic compare_beats(input string tag);
      check_eq({tag, "_nbeats"}, 64'(got_d.size()), 64'(exp_d.size()));
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         check_eq($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
         check_eq($sformatf("%s_keep%0d", tag, i), 64'(got_k[i]), 64'(exp_k[i]));
         check_eq($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
      end
   endtask

   task automatic check_gaps(input string tag, input int n, input int g);
      check_eq({tag, "_ngaps"}, 64'(gap_q.size()), 64'(n));
      foreach (gap_q[i]) check_eq($sformatf("%s_gap%0d", tag, i), 64'(gap_q[i]), 64'(g));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((a_busy || b_busy) && n < 3000) begin
         step();
         n++;
      end
      check_eq({tag, "_timeout"}, 64'(a_busy || b_busy), 64'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_sready"}, 64'(a_sready), 64'(1));
      check_eq({tag, "_tvalid"}, 64'(a_tvalid), 64'(0));
      check_eq({tag, "_tlast"},  64'(a_tlast),  64'(0));
      check_eq({tag, "_tdata"},  a_tdata,       64'(0));
      check_eq({tag, "_tkeep"},  64'(a_tkeep),  64'(0));
      check_eq({tag, "_tuser"},  64'(a_tuser),  64'(0));
      check_eq({tag, "_busy"},   64'(a_busy),   64'(0));
      check_eq({tag, "_pkt"},    64'(a_pkt),    64'(0));
      check_eq({tag, "_drop"},   64'(a_drop),   64'(0));
   endtask

   initial begin
      rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = '0; s_tkeep = '0;
      cfg_gap = 8'd0; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
      sel = 1'b0; mon_clr = 1'b0; rdy_mode = 1'b0;
      step(); step();
      check_reset_outs("rst_in");
      rst_n = 1'b1;
      step();
      check_reset_outs("rst_out");

      // back-to-back replay of 64/65/8 byte packets
      send_pkt(0, 64, 0, 0); send_pkt(1, 65, 0, 0); send_pkt(2, 8, 0, 0);
      check_eq("t1_pkt_count", 64'(a_pkt), 64'(3));
      new_run();
      exp_pkt(0, 64); exp_pkt(1, 65); exp_pkt(2, 8);
      pulse_start();
      check_eq("t1_busy_rise", 64'(a_busy), 64'(1));
      check_eq("t1_valid_rise", 64'(a_tvalid), 64'(1));
      wait_idle("t1");
      compare_beats("t1");
      if (got_k.size() == 18) begin
         check_eq("t1_lastkeep0", 64'(got_k[7]),  64'(8'hFF));
         check_eq("t1_lastkeep1", 64'(got_k[16]), 64'(8'h01));
         check_eq("t1_lastkeep2", 64'(got_k[17]), 64'(8'hFF));
      end
      check_gaps("t1", 2, 0);

      // gap 5 with tready toggling
      cfg_gap = 8'd5;
      rdy_mode = 1'b1;
      new_run();
      exp_pkt(0, 64); exp_pkt(1, 65); exp_pkt(2, 8);
      pulse_start();
      wait_idle("t2");
      rdy_mode = 1'b0;
      compare_beats("t2");
      check_gaps("t2", 2, 5);
      check_eq("t2_stalls_seen", 64'(hold_cnt > 0), 64'(1));
      check_eq("t2_hold_errs", 64'(hold_errs), 64'(0));

      // loop mode, stop during the third pass of packet 2
      cfg_gap = 8'd0;
      cfg_loop = 1'b1;
      clear = 1'b1; step(); clear = 1'b0;
      send_pkt(3, 16, 0, 0); send_pkt(4, 24, 0, 0);
      check_eq("t3_pkt_count", 64'(a_pkt), 64'(2));
      new_run();
      for (int r = 0; r < 3; r++) begin exp_pkt(3, 16); exp_pkt(4, 24); end
      pulse_start();
      for (int n = 0; n < 200 && got_d.size() < 13; n++) step();
      stop = 1'b1; step(); stop = 1'b0;
      wait_idle("t3");
      cfg_loop = 1'b0;
      compare_beats("t3");
      check_gaps("t3", 5, 0);

      // buffer overflow on the 16-word instance
      do_reset();
      sel = 1'b1;
      new_run();
      send_pkt(5, 80, 0, 0); send_pkt(6, 80, 0, 0);
      step();
      check_eq("t4_b_pkt_count", 64'(b_pkt), 64'(1));
      check_eq("t4_b_drops", 64'(drop_b), 64'(1));
      check_eq("t4_a_pkt_count", 64'(a_pkt), 64'(2));
      exp_pkt(5, 80);
      pulse_start();
      wait_idle("t4");
      compare_beats("t4");

      // table overflow, tuser drop, clear
      do_reset();
      sel = 1'b0;
      new_run();
      send_pkt(9, 24, 1, 0);
      step();
      check_eq("t5_user_drop", 64'(drop_a), 64'(1));
      check_eq("t5_user_pkt", 64'(a_pkt), 64'(0));
      for (int p = 0; p < 17; p++) send_pkt(10 + p, 8, 0, 0);
      step();
      check_eq("t5_full_pkt", 64'(a_pkt), 64'(16));
      check_eq("t5_full_drops", 64'(drop_a), 64'(2));
      clear = 1'b1; step(); clear = 1'b0;
      check_eq("t5_clear_pkt", 64'(a_pkt), 64'(0));
      send_pkt(30, 8, 0, 1);
      check_eq("t5_clear_wins", 64'(a_pkt), 64'(0));
      check_eq("t5_clear_nodrop", 64'(drop_a), 64'(2));
      pulse_start();
      step();
      check_eq("t5_start_ign_busy", 64'(a_busy), 64'(0));
      check_eq("t5_start_ign_valid", 64'(a_tvalid), 64'(0));

      // asynchronous reset in the middle of a packet
      send_pkt(7, 64, 0, 0);
      pulse_start();
      step(); step();
      check_eq("t6_pre_valid", 64'(a_tvalid), 64'(1));
      #2 rst_n = 1'b0;
      #1 check_reset_outs("t6_async");
      step();
      rst_n = 1'b1;
      step();
      check_eq("t6_sready", 64'(a_sready), 64'(1));
      check_eq("t6_pkt", 64'(a_pkt), 64'(0));
      check_eq("t6_valid", 64'(a_tvalid), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pcap_axis_player.md
Name: pcap_axis_player

Overview:
- Synthesizable, parametrised successor of the simulation-only pcap-to-AXIS source.
- Captures up to MAX_PKTS packets from a slave AXI4-Stream into an on-chip packet buffer, then replays them on a master AXI4-Stream.
- Replay honours tready, supports a runtime-programmable inter-packet gap including zero (true back-to-back), and supports loop mode.
- Used as a hardware traffic generator in front of the queueing system and as a reusable testbench source.

Parameters:
- AXIS_DATA_WIDTH, 64, stream data width in bits (multiple of 8).
- KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- BUF_WORDS, 1024, packet buffer depth in data words (power of 2).
- MAX_PKTS, 16, descriptor table depth (power of 2).
- GAP_WIDTH, 8, width of the inter-packet gap configuration.

Ports:
- clk_i, input, 1, single clock.
- rst_n_i, input, 1, asynchronous active-low reset.
- s_axis_tvalid_i / s_axis_tready_o / s_axis_tlast_i, in / out / in, 1 each, load stream handshake and end of packet.
- s_axis_tdata_i, input, AXIS_DATA_WIDTH, load data.
- s_axis_tkeep_i, input, KEEP_WIDTH, load byte enables.
- s_axis_tuser_i, input, 1, load error flag; packet is discarded when set on the tlast beat.
- m_axis_tvalid_o / m_axis_tready_i / m_axis_tlast_o, out / in / out, 1 each, replay handshake and end of packet.
- m_axis_tdata_o, output, AXIS_DATA_WIDTH, replay data.
- m_axis_tkeep_o, output, KEEP_WIDTH, replay byte enables.
- m_axis_tuser_o, output, 1, tied 0.
- cfg_gap_i, input, GAP_WIDTH, idle cycles between packets; sampled at each tlast handshake.
- cfg_loop_i, input, 1, 1 = wrap to packet 0 after the last stored packet.
- start_i / stop_i / clear_i, input, 1 each, single-cycle control pulses.
- busy_o, output, 1, high while replaying.
- pkt_count_o, output, $clog2(MAX_PKTS)+1, number of stored packets.
- drop_o, output, 1, one-cycle pulse when a load packet is discarded.

Behaviour:
- Reset state: all outputs 0 except s_axis_tready_o = 1. Descriptor table empty, write pointer 0, FSM in IDLE.
- States:
  - IDLE: loading allowed, s_axis_tready_o = 1.
  - PLAY: beats driven on the master stream, s_axis_tready_o = 0.
  - GAP: tvalid low while a gap counter runs.
- Load: each accepted beat is written at the write pointer.
  - On tlast, the descriptor {start address, word count, last tkeep} is pushed and pkt_count_o increments.
  - Non-last beats must carry all-ones tkeep. The last beat's tkeep is contiguous from the LSB and non-zero.
- Load drop rule:
  - If the buffer fills mid-packet, or the table is full at the first beat, remaining beats are still accepted but discarded until tlast.
  - On tlast the write pointer rewinds to the packet start and drop_o pulses.
  - A tuser=1 tlast beat is dropped the same way.
  - Stored packets are unaffected.
- start_i in IDLE with pkt_count_o > 0 enters PLAY at descriptor 0, and busy_o rises the next cycle.
  - The first beat's tvalid rises no later than 2 cycles after start_i is sampled.
  - start_i with pkt_count_o = 0, or while busy, is ignored.
- AXIS master rules:
  - Once tvalid is high, tdata/tkeep/tlast are held stable until the tready handshake.
  - tvalid never drops without a handshake.
  - Non-last beats drive tkeep all ones; the last beat drives the stored tkeep.
  - Bytes above tkeep are driven 0.
- Gap:
  - After a tlast handshake with cfg_gap_i = G > 0, tvalid stays low for exactly G cycles, then the next packet starts.
  - With G = 0, the next packet's first beat is valid in the cycle immediately after the handshake. This requires a one-word prefetch from the synchronous RAM.
- Sequencing:
  - After the last stored descriptor, the FSM wraps to descriptor 0 if cfg_loop_i = 1; otherwise it returns to IDLE and busy_o falls.
- stop_i during PLAY or GAP sets a stop-pending flag.
  - From PLAY, replay ends after the current packet's tlast handshake.
  - From GAP, the FSM goes straight to IDLE.
  - A packet is never truncated.
- clear_i:
  - In IDLE, it empties the table, zeroes pkt_count_o, and resets the write pointer the next cycle.
  - During PLAY, clear_i is ignored.
  - If clear_i and a load tlast coincide, clear wins.
- Asynchronous reset mid-packet: outputs return to their reset values immediately. No tlast is emitted and contents are lost.
- The buffer is linear with no wrap. The start address plus word count never exceeds BUF_WORDS.

Test Plan:
- Load 3 packets of 64/65/8 bytes (W=64) with tready held 1, then start with gap 0 → 8/9/1 beats, the last tkeeps 0xFF/0x01/0xFF, no idle cycles between packets, busy falls after packet 3.
- Same packets with cfg_gap_i = 5 and tready toggling 1-0-1-1-0 → data matches the loaded bytes, output is stable during stalls, exactly 5 idle cycles after each tlast handshake.
- cfg_loop_i = 1, 2 packets, stop_i asserted mid packet 2 on the third pass → packet 2 completes with tlast, then IDLE. Exactly 5 full packets plus the finished one.
- BUF_WORDS = 16: load a 10-word packet, then a 10-word packet → second packet dropped, drop_o pulses once, pkt_count_o = 1, replay emits only the first packet.
- Load 17 packets with MAX_PKTS = 16 → the 17th is dropped. A tuser=1 packet is also dropped. Then clear_i → pkt_count_o = 0 and start_i is ignored.
- Assert rst_n_i low mid-beat during PLAY → all outputs 0 asynchronously, s_axis_tready_o = 1 after release, pkt_count_o = 0.
